// File: rtl/aura_pkg.sv
// rtl/aura_pkg.sv - shared K/V vector types, sequence-length default and buffer FSM states
`ifndef MAX_SEQ_LENGTH
`define MAX_SEQ_LENGTH 1024
`endif

package aura_pkg;

    localparam int MAX_SEQ_LENGTH = `MAX_SEQ_LENGTH;
    localparam int VECTOR_W       = 512;

    typedef logic [VECTOR_W-1:0] K_VECTOR_T;
    typedef logic [VECTOR_W-1:0] V_VECTOR_T;

    typedef struct packed {
        logic      last;
        K_VECTOR_T data;
    } KV_ENTRY_T;

    // OPEN: block at base has no last flag stored yet; CLOSED: it has.
    typedef enum logic {
        BLK_OPEN   = 1'b0,
        BLK_CLOSED = 1'b1
    } blk_state_t;

endpackage

// File: rtl/kv_buffer_mem.sv
// rtl/kv_buffer_mem.sv - 1-write / 1-async-read register array holding {last, data} entries
module kv_buffer_mem #(
    parameter int WIDTH = 513,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_entry,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_entry
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_entry;
        end
    end

    // Combinational read; an SRAM macro here would add one cycle of read latency.
    assign rd_entry = mem[rd_addr];

endmodule

// File: rtl/kv_replay_buffer.sv
// rtl/kv_replay_buffer.sv - circular K/V block buffer replaying each block num_passes times
module kv_replay_buffer
    import aura_pkg::*;
#(
    parameter int DATA_W = VECTOR_W,
    parameter int DEPTH  = MAX_SEQ_LENGTH,
    parameter int PASS_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     wr_last,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_last,
    input  logic [PASS_W-1:0]        num_passes,
    output logic [PASS_W-1:0]        pass_idx,
    output logic                     block_done,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     overflow_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]     wr_ptr, rd_ptr, base;
    logic [PW-1:0]     last_cnt, last_cnt_d;
    logic [PASS_W-1:0] passes_lat, passes_eff, passes_req;
    logic [PASS_W-1:0] pass_idx_q;
    logic              overflow_q, overflow_cond;
    logic              full, wr_fire, rd_fire, pass_load, rewind;
    logic [DATA_W:0]   rd_entry;
    blk_state_t        state_q, state_d;

    kv_buffer_mem #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk      (clk),
        .wr_en    (wr_fire),
        .wr_addr  (wr_ptr[AW-1:0]),
        .wr_entry ({wr_last, wr_data}),
        .rd_addr  (rd_ptr[AW-1:0]),
        .rd_entry (rd_entry)
    );

    assign rd_data   = rd_entry[DATA_W-1:0];
    assign rd_last   = rd_entry[DATA_W];
    assign occupancy = wr_ptr - base;
    assign full      = (occupancy == PW'(DEPTH));
    assign wr_ready  = !full;
    assign rd_valid  = (rd_ptr != wr_ptr);
    assign wr_fire   = wr_valid && wr_ready;
    assign rd_fire   = rd_valid && rd_ready;
    assign pass_idx  = pass_idx_q;

    // Pass count is latched on the first read of a block so a single-entry
    // block already sees the new value on its only handshake.
    assign passes_req = (num_passes == '0) ? PASS_W'(1) : num_passes;
    assign pass_load  = rd_fire && (rd_ptr == base) && (pass_idx_q == '0);
    assign passes_eff = pass_load ? passes_req : passes_lat;

    assign overflow_cond = full && (state_q == BLK_OPEN) && (passes_lat > PASS_W'(1));
    assign overflow_err  = overflow_q || overflow_cond;

    always_comb begin
        rewind     = 1'b0;
        block_done = 1'b0;
        state_d    = state_q;
        if (rd_fire && rd_last) begin
            if (pass_idx_q < passes_eff - PASS_W'(1)) begin
                rewind = 1'b1;
            end else begin
                block_done = 1'b1;
            end
        end
        last_cnt_d = last_cnt + PW'(wr_fire && wr_last) - PW'(block_done);
        case (state_q)
            BLK_OPEN: begin
                if (wr_fire && wr_last) begin
                    state_d = BLK_CLOSED;
                end
            end
            BLK_CLOSED: begin
                if (block_done) begin
                    state_d = (last_cnt_d != '0) ? BLK_CLOSED : BLK_OPEN;
                end
            end
            default: state_d = BLK_OPEN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            base       <= '0;
            last_cnt   <= '0;
            pass_idx_q <= '0;
            passes_lat <= PASS_W'(1);
            overflow_q <= 1'b0;
            state_q    <= BLK_OPEN;
        end else begin
            state_q  <= state_d;
            last_cnt <= last_cnt_d;
            if (wr_fire) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pass_load) begin
                passes_lat <= passes_req;
            end
            if (rd_fire) begin
                if (!rd_last) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end else if (rewind) begin
                    rd_ptr     <= base;
                    pass_idx_q <= pass_idx_q + PASS_W'(1);
                end else begin
                    base       <= rd_ptr + PW'(1);
                    rd_ptr     <= rd_ptr + PW'(1);
                    pass_idx_q <= '0;
                end
            end
            if (overflow_cond) begin
                overflow_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_kv_replay_buffer.sv
// tb/tb_kv_replay_buffer.sv - scoreboard bench for kv_replay_buffer (DEPTH=8, DATA_W=16)
module tb_kv_replay_buffer;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;
    localparam int PASS_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              wr_last;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic [PASS_W-1:0] num_passes;
    logic [PASS_W-1:0] pass_idx;
    logic              block_done;
    logic [3:0]        occupancy;
    logic              overflow_err;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
        logic [PASS_W-1:0] pass;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;

    kv_replay_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PASS_W (PASS_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .wr_last      (wr_last),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .rd_last      (rd_last),
        .num_passes   (num_passes),
        .pass_idx     (pass_idx),
        .block_done   (block_done),
        .occupancy    (occupancy),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    // Inputs change at posedge+1; a handshake seen here completes at the next posedge.
    always @(negedge clk) begin
        if (!rst && rd_valid && rd_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: got data=%h last=%b pass=%0d, expected no read", rd_data, rd_last, pass_idx);
            end else begin
                mon_e = exp_q.pop_front();
                if ({rd_last, pass_idx, rd_data} !== {mon_e.last, mon_e.pass, mon_e.data}) begin
                    errors++;
                    $display("FAIL rd_entry: got data=%h last=%b pass=%0d, expected data=%h last=%b pass=%0d",
                             rd_data, rd_last, pass_idx, mon_e.data, mon_e.last, mon_e.pass);
                end
            end
        end
        if (!rst && block_done) done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic do_write(input logic [DATA_W-1:0] d, input logic l, input int budget, output bit ok);
        wr_valid = 1'b1;
        wr_data  = d;
        wr_last  = l;
        ok       = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (wr_ready) ok = 1'b1;
            step();
            if (ok) break;
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic write_block(input logic [DATA_W-1:0] first, input int n, input int passes);
        bit ok;
        num_passes = PASS_W'(passes);
        for (int i = 0; i < n; i++) begin
            do_write(first + DATA_W'(i), (i == n - 1), 20, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL write_accept: got wr_ready=0 for data=%h, expected accept", first + DATA_W'(i));
            end
        end
        for (int p = 0; p < ((passes == 0) ? 1 : passes); p++)
            for (int i = 0; i < n; i++)
                exp_q.push_back('{data: first + DATA_W'(i), last: (i == n - 1), pass: PASS_W'(p)});
    endtask

    task automatic read_until(input int remaining, input int budget);
        bit hit = 1'b0;
        rd_ready = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() <= remaining) begin
                hit = 1'b1;
                break;
            end
        end
        step();
        rd_ready = 1'b0;
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL read_timeout: got %0d pending reads, expected %0d", exp_q.size(), remaining);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({rd_valid, wr_ready, occupancy, pass_idx, block_done, overflow_err} !== {1'b0, 1'b1, 4'd0, 8'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got rd_valid=%b wr_ready=%b occ=%0d pass=%0d done=%b ovf=%b, expected 0 1 0 0 0 0",
                     rd_valid, wr_ready, occupancy, pass_idx, block_done, overflow_err);
        end
        step();
    endtask

    task automatic test_single_pass();
        int d0 = done_cnt;
        write_block(16'h0001, 5, 1);
        @(negedge clk);
        checks++;
        if (occupancy !== 4'd5) begin
            errors++;
            $display("FAIL single_occ_full: got %0d, expected 5", occupancy);
        end
        step();
        read_until(0, 50);
        @(negedge clk);
        checks++;
        if (occupancy !== 4'd0 || done_cnt !== d0 + 1) begin
            errors++;
            $display("FAIL single_done: got occ=%0d blocks=%0d, expected occ=0 blocks=%0d", occupancy, done_cnt - d0, 1);
        end
        step();
    endtask

    task automatic test_multi_pass();
        int d0  = done_cnt;
        int bad = 0;
        bit hit = 1'b0;
        write_block(16'h00A0, 4, 3);
        rd_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt == d0 && occupancy !== 4'd4) bad++;
            if (done_cnt != d0 && exp_q.size() != 0) bad++;
            if (exp_q.size() == 0) begin
                hit = 1'b1;
                break;
            end
        end
        step();
        rd_ready = 1'b0;
        checks++;
        if (!hit || bad != 0) begin
            errors++;
            $display("FAIL multi_hold: got %0d bad cycles, %0d pending reads, expected 0 and 0", bad, exp_q.size());
        end
        @(negedge clk);
        checks++;
        if (occupancy !== 4'd0 || done_cnt !== d0 + 1) begin
            errors++;
            $display("FAIL multi_done: got occ=%0d blocks=%0d, expected occ=0 blocks=1", occupancy, done_cnt - d0);
        end
        step();
    endtask

    task automatic test_back_pressure();
        int d0  = done_cnt;
        bit hit = 1'b0;
        write_block(16'h00B0, 4, 2);
        write_block(16'h00C0, 4, 2);
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b0 || occupancy !== 4'd8) begin
            errors++;
            $display("FAIL bp_full: got wr_ready=%b occ=%0d, expected 0 and 8", wr_ready, occupancy);
        end
        step();
        rd_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != d0) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit || wr_ready !== 1'b0 || exp_q.size() != 8) begin
            errors++;
            $display("FAIL bp_done_cycle: got done=%b wr_ready=%b pending=%0d, expected 1 0 8", hit, wr_ready, exp_q.size());
        end
        step();
        rd_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b1 || occupancy !== 4'd4) begin
            errors++;
            $display("FAIL bp_after_done: got wr_ready=%b occ=%0d, expected 1 and 4", wr_ready, occupancy);
        end
        step();
        read_until(0, 40);
        checks++;
        if (done_cnt !== d0 + 2) begin
            errors++;
            $display("FAIL bp_blocks: got %0d, expected 2", done_cnt - d0);
        end
    endtask

    task automatic test_wrap();
        int d0 = done_cnt;
        do_reset();
        write_block(16'h0060, 6, 1);
        read_until(0, 30);
        write_block(16'h00D0, 4, 2);
        read_until(0, 40);
        @(negedge clk);
        checks++;
        if (done_cnt !== d0 + 2 || occupancy !== 4'd0) begin
            errors++;
            $display("FAIL wrap_done: got blocks=%0d occ=%0d, expected 2 and 0", done_cnt - d0, occupancy);
        end
        step();
    endtask

    task automatic test_overflow();
        bit ok;
        do_reset();
        num_passes = 8'd2;
        do_write(16'h00E0, 1'b0, 10, ok);
        exp_q.push_back('{data: 16'h00E0, last: 1'b0, pass: 8'd0});
        read_until(0, 10);
        for (int i = 1; i < 7; i++) do_write(16'h00E0 + 16'(i), 1'b0, 10, ok);
        @(negedge clk);
        checks++;
        if (overflow_err !== 1'b0 || occupancy !== 4'd7) begin
            errors++;
            $display("FAIL ovf_before: got ovf=%b occ=%0d, expected 0 and 7", overflow_err, occupancy);
        end
        step();
        do_write(16'h00E7, 1'b0, 10, ok);
        @(negedge clk);
        checks++;
        if (overflow_err !== 1'b1 || occupancy !== 4'd8 || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL ovf_set: got ovf=%b occ=%0d wr_ready=%b, expected 1 8 0", overflow_err, occupancy, wr_ready);
        end
        step();
        do_write(16'h00E8, 1'b0, 4, ok);
        repeat (3) step();
        @(negedge clk);
        checks++;
        if (ok !== 1'b0 || overflow_err !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got accepted=%b ovf=%b, expected 0 and 1", ok, overflow_err);
        end
        step();
        do_reset();
        @(negedge clk);
        checks++;
        if (overflow_err !== 1'b0 || occupancy !== 4'd0) begin
            errors++;
            $display("FAIL ovf_clear: got ovf=%b occ=%0d, expected 0 and 0", overflow_err, occupancy);
        end
        step();
    endtask

    task automatic test_reset_mid_block();
        int d0;
        do_reset();
        write_block(16'h00F0, 4, 2);
        read_until(2, 30);
        @(negedge clk);
        checks++;
        if (pass_idx !== 8'd1) begin
            errors++;
            $display("FAIL mid_pass: got %0d, expected 1", pass_idx);
        end
        step();
        do_reset();
        @(negedge clk);
        checks++;
        if ({rd_valid, occupancy, pass_idx, wr_ready} !== {1'b0, 4'd0, 8'd0, 1'b1}) begin
            errors++;
            $display("FAIL mid_reset: got rd_valid=%b occ=%0d pass=%0d wr_ready=%b, expected 0 0 0 1",
                     rd_valid, occupancy, pass_idx, wr_ready);
        end
        step();
        d0 = done_cnt;
        write_block(16'h0B00, 3, 1);
        read_until(0, 20);
        checks++;
        if (done_cnt !== d0 + 1) begin
            errors++;
            $display("FAIL mid_fresh: got %0d blocks, expected 1", done_cnt - d0);
        end
    endtask

    initial begin
        rst        = 1'b1;
        wr_valid   = 1'b0;
        wr_data    = '0;
        wr_last    = 1'b0;
        rd_ready   = 1'b0;
        num_passes = 8'd1;
        test_reset();
        test_single_pass();
        test_multi_pass();
        test_back_pressure();
        test_wrap();
        test_overflow();
        test_reset_mid_block();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/kv_replay_buffer.md
Name: kv_replay_buffer

Overview:
Parametrised K/V vector buffer between the memory controller and the backend PE array. It is a power-of-two circular buffer that groups entries into blocks; a block ends with the entry written with wr_last. Each block is streamed to the backend num_passes times, one pass per Q tile. Entries are freed only on the final pass, so the memory controller fetches each K/V row once instead of once per Q tile.

Parameters:
DATA_W, 512, width in bits of one vector (packed K_VECTOR_T / V_VECTOR_T)
DEPTH, `MAX_SEQ_LENGTH, entries; must be a power of two, at least 2
PASS_W, 8, width of the pass counter and of num_passes

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
wr_valid  in  1  producer has a vector
wr_ready  out  1  buffer can accept a vector (not full)
wr_data  in  DATA_W  vector
wr_last  in  1  vector is the final entry of the current block
rd_valid  out  1  rd_data is valid
rd_ready  in  1  backend consumes rd_data
rd_data  out  DATA_W  vector at the read pointer, combinational
rd_last  out  1  stored last flag of the rd_data entry
num_passes  in  PASS_W  passes per block; 0 is treated as 1; sampled at block start
pass_idx  out  PASS_W  current pass number, 0-based
block_done  out  1  one-cycle pulse on the final-pass rd_last handshake
occupancy  out  $clog2(DEPTH)+1  entries held, freed only on the final pass
overflow_err  out  1  sticky: block longer than DEPTH with more than one pass

Behaviour:
- Storage: mem[DEPTH] of {last, data}. Contents are not reset; rd_data/rd_last are don't-care while rd_valid=0.
- Pointers wr_ptr, rd_ptr, base, each $clog2(DEPTH)+1 bits with a wrap bit. base is the first entry of the current block.
- occupancy = wr_ptr - base. full = occupancy==DEPTH. wr_ready = !full. rd_valid = (rd_ptr != wr_ptr).
- Write (wr_valid & wr_ready): mem[wr_ptr] <= {wr_last, wr_data}; wr_ptr++.
- Read (rd_valid & rd_ready), first matching case applies:
  - rd_last=0: rd_ptr++.
  - rd_last=1 and pass_idx < passes_lat-1: rd_ptr <= base, pass_idx++. This is the rewind.
  - rd_last=1 and final pass: base <= rd_ptr+1, rd_ptr <= rd_ptr+1, pass_idx <= 0, block_done=1 that cycle.
- passes_lat: loaded from max(num_passes,1) on a read handshake when rd_ptr==base and pass_idx==0.
  - Until that load, the previous value holds; the reset value is 1.
  - A num_passes change mid-block has no effect on that block.
- Latency: a write becomes readable the next cycle; no write-to-read bypass. Pass 0 may stream while the block is still filling.
- Simultaneous read and write: both take effect in the same cycle. Entries freed by the final rd_last free space the next cycle, so wr_ready rises the cycle after block_done.
- Two FSM states:
  - OPEN: last flag not yet written for the block at base.
  - CLOSED: last flag written. Enter CLOSED on a wr_last write; return to OPEN on block_done unless a later last entry already exists. Track with a count of stored last flags.
- overflow_err: sets when full && OPEN && passes_lat>1 (deadlock condition). It clears only on rst. The buffer keeps operating; pass-1 behaviour is unaffected.
- Wrap-around: pointers index mem with their low bits; a rewind across the wrap must replay in the correct order.
- Reset, including mid-block: all pointers 0, pass_idx 0, passes_lat 1, rd_valid 0, wr_ready 1, block_done 0, overflow_err 0, occupancy 0. Any partial block is discarded.

Decomposition:
- aura_pkg: K_VECTOR_T/V_VECTOR_T, `MAX_SEQ_LENGTH, and a KV_ENTRY_T struct {logic last; vector data}.
- One natural sub-module: kv_buffer_mem, a 1-write/1-async-read register array. It allows later swap to an SRAM macro with a registered read, which would add one cycle of rd latency.

Test Plan:
- DEPTH=8, DATA_W=16, num_passes=1: write 0x0001..0x0005 with wr_last on 0x0005, then read with rd_ready=1. Expect 0x0001..0x0005 in order, rd_last on 0x0005, one block_done, occupancy 5→0.
- num_passes=3, 4-entry block 0xA0..0xA3: expect 12 reads (A0..A3 three times) with pass_idx 0,1,2. occupancy stays 4 until the final rd_last; block_done only after the 12th read.
- Write 8 entries (two blocks of 4, passes=2) until wr_ready=0. Finish block 1 with 8 reads: wr_ready returns the cycle after block_done and occupancy=4.
- Wrap: pre-advance pointers by 6, then a 4-entry block with passes=2. The replay crosses index 7→0 and the order is preserved.
- 9 writes with no wr_last, passes=2, DEPTH=8: overflow_err=1 when occupancy hits 8 and stays 1 until rst.
- Assert rst during pass 1 of a block: next cycle rd_valid=0, occupancy=0, pass_idx=0, wr_ready=1. A fresh block then streams correctly.
